mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Responder side of the core's ihit/dhit handshake. Arbitrates instruction-fetch and data requests from the datapath onto a single-ported RAM and returns one-cycle ihit/dhit pulses. The pipeline's stall/flush logic consumes those pulses. Sits between the datapath/cache request signals and the RAM model. Data has priority over instruction; a watchdog flags hung transactions.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data word width in bits
TIMEOUT, 255, max cycles waiting for RAM ACCESS before error; counter width is clog2(TIMEOUT+1)
FAIR_LIMIT, 4, consecutive data grants allowed while iREN pending (used only with MEMARB_FAIR_EN)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  instruction read request (level)
iaddr  in  ADDR_W  instruction address
iload  out  DATA_W  instruction data, valid when ihit=1
ihit  out  1  one-cycle instruction completion pulse
dREN  in  1  data read request (level)
dWEN  in  1  data write request (level)
daddr  in  ADDR_W  data address
dstore  in  DATA_W  write data
dload  out  DATA_W  read data, valid when dhit=1
dhit  out  1  one-cycle data completion pulse (reads and writes)
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  out  1  sticky error flag

Behaviour:
- Reset, asynchronous, nRST=0: state=IDLE; all latches, timeout counter and fairness counter cleared. Outputs ihit=dhit=ramREN=ramWEN=err=0; ramaddr=ramstore=iload=dload=0.
- States: IDLE, DREQ, IREQ, ERR.
- IDLE:
  - dREN^dWEN → latch daddr, dstore and op; go to DREQ.
  - Else iREN → latch iaddr; go to IREQ.
  - dREN&dWEN together → go to ERR.
  - No request → stay in IDLE.
- DREQ/IREQ:
  - ramREN/ramWEN driven from registered state and latched op; ramaddr/ramstore come from the latches. RAM outputs never change mid-transaction.
  - ramstate==ACCESS → pulse dhit (or ihit) in that same cycle. dload/iload = ramload combinationally while the hit is high, 0 otherwise. Next state is IDLE.
  - Requester deasserts its request before ACCESS → abort to IDLE, no hit, RAM strobes drop next cycle.
  - ramstate==ERROR → go to ERR.
  - Timeout counter increments each cycle not in ACCESS; count reaching TIMEOUT → go to ERR. Counter clears on entering IDLE.
- Latency: request first seen in IDLE at cycle 0 → strobes at cycle 1 → hit no earlier than cycle 1 (zero-wait RAM) → IDLE at cycle 2. Minimum one bubble between back-to-back transactions.
- ihit and dhit are never high in the same cycle; each is high for exactly 1 cycle per completed transaction.
- ERR: all strobes and hits are 0; err=1 and stays 1 until nRST. No further grants.
- Address/data inputs are don't-care outside the IDLE latch cycle.

Optional Feature:
MEMARB_FAIR_EN.
- Defined: a saturating counter counts consecutive data grants made while iREN was high. When it reaches FAIR_LIMIT, the next IDLE decision grants instruction even if a data request is pending. The counter clears on any instruction grant or when iREN=0 at decision time.
- Undefined: strict data priority; counter logic absent.

Decomposition:
- Package cpu_types_pkg gets ramstate_t (2-bit enum FREE/BUSY/ACCESS/ERROR), arb_state_t (IDLE/DREQ/IREQ/ERR) and word_t.
- One natural sub-module, arb_watchdog: the TIMEOUT counter, with inputs clear and count_en and a terminal-count output.
- The rest stays in mem_arbiter.

Test Plan:
- Instruction read, zero-wait: iREN=1, iaddr=0x40, ramstate=ACCESS, ramload=0xDEADBEEF → ramREN=1 with ramaddr=0x40 at cycle 1; ihit=1 and iload=0xDEADBEEF at cycle 1; IDLE at cycle 2.
- Data priority: iREN=1 and dWEN=1 in the same cycle, daddr=0x80, dstore=0x1234, RAM 2 wait states → ramWEN with ramaddr=0x80 and ramstore=0x1234. dhit at cycle 3, then the instruction transaction starts at cycle 4.
- Abort: dREN=1, ramstate=BUSY, dREN dropped at cycle 2 → no dhit, ramREN=0 at cycle 3, state IDLE.
- Errors:
  - ramstate=ERROR during IREQ → err=1 persistently, no ihit.
  - dREN=dWEN=1 in IDLE → err=1.
  - nRST pulse → err=0, IDLE.
- Timeout: TIMEOUT=8, ramstate held BUSY → err asserted after 8 waiting cycles, strobes drop.
- With MEMARB_FAIR_EN, FAIR_LIMIT=4: continuous dREN and iREN → fifth grant is an instruction (ihit after 4 dhits). Without the macro → no ihit while dREN is held.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states, arbiter FSM states, word type.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2,
        ERR  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Datapath/cache request bus plus RAM-side bus seen by the memory arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import cpu_types_pkg::*;

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] iload;
    logic              ihit;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dhit;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;
    logic              err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Wait-cycle counter for a pending RAM transaction; tc_o fires on the cycle the count reaches TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic tc_o
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, saturate at TIMEOUT
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (count_en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = count_en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter with data-over-instruction priority and a hang watchdog.
// Optional instruction fairness is enabled by defining MEMARB_FAIR_EN.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 255,
    parameter int FAIR_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              op_wr_q, op_wr_d;
    logic              busy_s;
    logic              req_alive_s;
    logic              tc_s;
    logic              fair_force_s;
    logic              grant_d_s;
    logic              grant_i_s;

    assign busy_s    = (state_q == DREQ) || (state_q == IREQ);
    assign grant_d_s = (state_q == IDLE) && (state_d == DREQ);
    assign grant_i_s = (state_q == IDLE) && (state_d == IREQ);

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk        (CLK),
        .rst_n      (nRST),
        .clear_i    (state_q == IDLE),
        .count_en_i (busy_s && (bus.ramstate != ACCESS)),
        .tc_o       (tc_s)
    );

`ifdef MEMARB_FAIR_EN
    localparam int FAIR_W = $clog2(FAIR_LIMIT + 1);

    logic [FAIR_W-1:0] fair_q, fair_d;

    assign fair_force_s = (fair_q == FAIR_W'(FAIR_LIMIT)) && bus.iREN;

    // Consecutive data grants made while an instruction fetch was waiting
    always_comb begin
        fair_d = fair_q;
        if (grant_i_s) begin
            fair_d = {FAIR_W{1'b0}};
        end else if (grant_d_s) begin
            if (bus.iREN) begin
                fair_d = (fair_q == FAIR_W'(FAIR_LIMIT)) ? fair_q : fair_q + FAIR_W'(1);
            end else begin
                fair_d = {FAIR_W{1'b0}};
            end
        end else begin
            fair_d = fair_q;
        end
    end

    // Fairness counter register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fair_q <= {FAIR_W{1'b0}};
        end else begin
            fair_q <= fair_d;
        end
    end
`else
    logic unused_fair_s;
    assign unused_fair_s = FAIR_LIMIT[0];
    assign fair_force_s  = 1'b0;
`endif

    // The granted requester must keep its own request line up or the access is abandoned
    always_comb begin
        req_alive_s = 1'b0;
        case (state_q)
            DREQ:    req_alive_s = op_wr_q ? bus.dWEN : bus.dREN;
            IREQ:    req_alive_s = bus.iREN;
            default: req_alive_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.dREN && bus.dWEN) begin
                    state_d = ERR;
                end else if ((bus.dREN ^ bus.dWEN) && !fair_force_s) begin
                    state_d = DREQ;
                end else if (bus.iREN) begin
                    state_d = IREQ;
                end else begin
                    state_d = IDLE;
                end
            end
            DREQ, IREQ: begin
                if (bus.ramstate == ERROR) begin
                    state_d = ERR;
                end else if (bus.ramstate == ACCESS) begin
                    state_d = IDLE;
                end else if (!req_alive_s) begin
                    state_d = IDLE;
                end else if (tc_s) begin
                    state_d = ERR;
                end else begin
                    state_d = state_q;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Request latches, loaded only on the IDLE grant so the RAM sees stable values
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        op_wr_d = op_wr_q;
        if (grant_d_s) begin
            addr_d  = bus.daddr;
            data_d  = bus.dstore;
            op_wr_d = bus.dWEN;
        end else if (grant_i_s) begin
            addr_d  = bus.iaddr;
            op_wr_d = 1'b0;
        end else begin
            addr_d  = addr_q;
        end
    end

    // Latch registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            addr_q  <= {ADDR_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            op_wr_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_wr_q <= op_wr_d;
        end
    end

    // FSM outputs: strobes from registered state, hits qualified by ramstate
    always_comb begin
        bus.ramREN   = (state_q == IREQ) || ((state_q == DREQ) && !op_wr_q);
        bus.ramWEN   = (state_q == DREQ) && op_wr_q;
        bus.ramaddr  = addr_q;
        bus.ramstore = data_q;
        bus.ihit     = (state_q == IREQ) && (bus.ramstate == ACCESS);
        bus.dhit     = (state_q == DREQ) && (bus.ramstate == ACCESS);
        bus.err      = (state_q == ERR);
        if (bus.ihit) begin
            bus.iload = bus.ramload;
        end else begin
            bus.iload = {DATA_W{1'b0}};
        end
        if (bus.dhit) begin
            bus.dload = bus.ramload;
        end else begin
            bus.dload = {DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand-written error, timeout and fairness sequences.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int FL = 4;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    always #5 CLK = ~CLK;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .FAIR_LIMIT(FL)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        ramstate_t   rs;
        logic [31:0] rload;
        logic        e_ihit;
        logic        e_dhit;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s #%0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.iREN     = v.iren;
        bus.iaddr    = v.iaddr;
        bus.dREN     = v.dren;
        bus.dWEN     = v.dwen;
        bus.daddr    = v.daddr;
        bus.dstore   = v.dstore;
        bus.ramstate = v.rs;
        bus.ramload  = v.rload;
    endtask

    task automatic drive_idle();
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = 32'h0;
        bus.dstore   = 32'h0;
        bus.ramstate = FREE;
        bus.ramload  = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive_idle();
        @(negedge CLK);
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        next_cycle();
    endtask

    task automatic check_all_zero(input string tag, input int idx);
        chk({tag, "_ihit"},   idx, {31'b0, bus.ihit},   32'h0);
        chk({tag, "_dhit"},   idx, {31'b0, bus.dhit},   32'h0);
        chk({tag, "_ramREN"}, idx, {31'b0, bus.ramREN}, 32'h0);
        chk({tag, "_ramWEN"}, idx, {31'b0, bus.ramWEN}, 32'h0);
        chk({tag, "_err"},    idx, {31'b0, bus.err},    32'h0);
        chk({tag, "_ramaddr"},  idx, bus.ramaddr,  32'h0);
        chk({tag, "_ramstore"}, idx, bus.ramstore, 32'h0);
        chk({tag, "_iload"},    idx, bus.iload,    32'h0);
        chk({tag, "_dload"},    idx, bus.dload,    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int dcount;
        int icount;
        int d_before_i;
        logic both_seen;

        // One row per clock cycle: inputs for that cycle, outputs expected in that cycle
        // iren iaddr     dren dwen daddr     dstore     rs      rload    | ihit dhit ren wen addr      store      iload      dload      err
        vecs.push_back('{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,    ACCESS, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,    ACCESS, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0,    32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,    FREE,   32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,    32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h44,  1'b0, 1'b1, 32'h80,  32'h1234, BUSY,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,    32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h44,  1'b0, 1'b1, 32'h99,  32'h5678, BUSY,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h80,  32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h44,  1'b0, 1'b1, 32'h99,  32'h5678, BUSY,   32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h80,  32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h44,  1'b0, 1'b1, 32'h99,  32'h5678, ACCESS, 32'h5555,     1'b0, 1'b1, 1'b0, 1'b1, 32'h80,  32'h1234, 32'h0,        32'h5555,     1'b0});
        vecs.push_back('{1'b1, 32'h44,  1'b0, 1'b0, 32'h99,  32'h5678, FREE,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h80,  32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h44,  1'b0, 1'b0, 32'h99,  32'h5678, ACCESS, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 32'h44,  32'h1234, 32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h44,  1'b0, 1'b0, 32'h0,   32'h0,    FREE,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h44,  32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h1234, BUSY,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h44,  32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h1234, BUSY,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 32'h1234, BUSY,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h100, 32'h1234, ACCESS, 32'h77,       1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 32'h1234, ACCESS, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h200, 32'h1234, ACCESS, 32'h0BADF00D, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, 32'h1234, 32'h0,        32'h0BADF00D, 1'b0});
        vecs.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h200, 32'h1234, FREE,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   32'h0,    BUSY,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   32'h0,    ERROR,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h1234, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   32'h0,    ACCESS, 32'hAAAA,     1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h1234, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,    ACCESS, 32'hAAAA,     1'b0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h1234, 32'h0,        32'h0,        1'b1});

        // Reset state
        drive_idle();
        nRST = 1'b0;
        #12;
        check_all_zero("reset", 0);
        @(negedge CLK);
        nRST = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge CLK);
            chk("ihit",     i, {31'b0, bus.ihit},   {31'b0, vecs[i].e_ihit});
            chk("dhit",     i, {31'b0, bus.dhit},   {31'b0, vecs[i].e_dhit});
            chk("ramREN",   i, {31'b0, bus.ramREN}, {31'b0, vecs[i].e_ren});
            chk("ramWEN",   i, {31'b0, bus.ramWEN}, {31'b0, vecs[i].e_wen});
            chk("ramaddr",  i, bus.ramaddr,  vecs[i].e_addr);
            chk("ramstore", i, bus.ramstore, vecs[i].e_store);
            chk("iload",    i, bus.iload,    vecs[i].e_iload);
            chk("dload",    i, bus.dload,    vecs[i].e_dload);
            chk("err",      i, {31'b0, bus.err}, {31'b0, vecs[i].e_err});
            next_cycle();
        end

        // nRST pulse clears the sticky error and returns to IDLE
        drive_idle();
        #2;
        nRST = 1'b0;
        #1;
        check_all_zero("rst_pulse", 0);
        #2;
        nRST = 1'b1;
        next_cycle();
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h10;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h1111;
        next_cycle();
        @(negedge CLK);
        chk("post_rst_ihit",  0, {31'b0, bus.ihit}, 32'h1);
        chk("post_rst_iload", 0, bus.iload, 32'h1111);

        // Simultaneous read and write request is fatal
        do_reset();
        bus.dREN = 1'b1;
        bus.dWEN = 1'b1;
        bus.ramstate = ACCESS;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("dual_err",    k, {31'b0, bus.err},    32'h1);
            chk("dual_ramREN", k, {31'b0, bus.ramREN}, 32'h0);
            chk("dual_ramWEN", k, {31'b0, bus.ramWEN}, 32'h0);
            chk("dual_dhit",   k, {31'b0, bus.dhit},   32'h0);
            next_cycle();
        end

        // Timeout: RAM stuck BUSY, TIMEOUT=8 wait cycles
        do_reset();
        bus.dREN     = 1'b1;
        bus.daddr    = 32'h500;
        bus.ramstate = BUSY;
        for (int k = 0; k < 8; k++) next_cycle();
        @(negedge CLK);
        chk("to_wait_ramREN", 8, {31'b0, bus.ramREN}, 32'h1);
        chk("to_wait_err",    8, {31'b0, bus.err},    32'h0);
        next_cycle();
        @(negedge CLK);
        chk("to_err",    9, {31'b0, bus.err},    32'h1);
        chk("to_ramREN", 9, {31'b0, bus.ramREN}, 32'h0);

        // Continuous data and instruction requests with a zero-wait RAM
        do_reset();
        bus.dREN     = 1'b1;
        bus.iREN     = 1'b1;
        bus.ramstate = ACCESS;
        bus.ramload  = 32'h2222;
        dcount     = 0;
        icount     = 0;
        d_before_i = -1;
        both_seen  = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge CLK);
            if (bus.ihit && bus.dhit) begin
                both_seen = 1'b1;
            end
            if (bus.ihit) begin
                if (icount == 0) d_before_i = dcount;
                icount++;
            end
            if (bus.dhit) begin
                dcount++;
            end
            next_cycle();
        end
        chk("hits_exclusive", 0, {31'b0, both_seen}, 32'h0);
`ifdef MEMARB_FAIR_EN
        chk("fair_dhits_before_ihit", 0, d_before_i, 32'd4);
        chk("fair_total_hits", 0, dcount + icount, 32'd12);
`else
        chk("strict_ihits", 0, icount, 32'd0);
        chk("strict_dhits", 0, dcount, 32'd12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
